// File: rtl/mem_arbiter_if.sv
// One requester port of the memory arbiter: registered req/ack access.
// master = requester side, slave = arbiter side.
interface mem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          req;
  logic          lock;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ack;
  logic [DW-1:0] rdata;

  modport master (
    output req, lock, we, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, lock, we, addr, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter/sequencer for a single-port async-read memory.
// Each access runs IDLE -> ACC -> RESP; optional bounded lock for bursts.
module mem_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  a_if,
  mem_arbiter_if.slave  b_if,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          mem_we,
  input  logic [DW-1:0] mem_dout,
  output logic          busy
);

  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e        state_q;
  logic          owner_q;
  logic          rr_q;
  logic [BW-1:0] burst_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          a_ack_q;
  logic          b_ack_q;
  logic [DW-1:0] a_rdata_q;
  logic [DW-1:0] b_rdata_q;

  logic          own_lock;
  logic          hold;
  logic          any_req;
  logic          win_d;
  logic [BW-1:0] burst_d;

  // Port encoding: 0 = A, 1 = B.
  always_comb begin
    own_lock = owner_q ? (b_if.req & b_if.lock)
                       : (a_if.req & a_if.lock);
    hold     = own_lock && (burst_q < BW'(MAX_BURST));
    any_req  = a_if.req | b_if.req;
    win_d    = b_if.req;
    burst_d  = BW'(1);
    if (hold) begin
      win_d   = owner_q;
      burst_d = burst_q + BW'(1);
    end else if (a_if.req && b_if.req) begin
      win_d   = rr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      rr_q      <= 1'b0;
      burst_q   <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q <= ACC;
            owner_q <= win_d;
            burst_q <= burst_d;
            we_q    <= win_d ? b_if.we : a_if.we;
            addr_q  <= win_d ? b_if.addr : a_if.addr;
            wdata_q <= win_d ? b_if.wdata : a_if.wdata;
          end
        end
        ACC: begin
          state_q <= RESP;
          a_ack_q <= ~owner_q;
          b_ack_q <= owner_q;
          if (!we_q) begin
            if (owner_q) b_rdata_q <= mem_dout;
            else         a_rdata_q <= mem_dout;
          end
        end
        RESP: begin
          state_q <= IDLE;
          a_ack_q <= 1'b0;
          b_ack_q <= 1'b0;
          rr_q    <= ~owner_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory pins decode from state so reset drops mem_we immediately.
  assign mem_addr   = addr_q;
  assign mem_din    = wdata_q;
  assign mem_we     = (state_q == ACC) & we_q;
  assign busy       = (state_q != IDLE);
  assign a_if.ack   = a_ack_q;
  assign a_if.rdata = a_rdata_q;
  assign b_if.ack   = b_ack_q;
  assign b_if.rdata = b_rdata_q;

endmodule
